// File: rtl/wifi_preamble_pkg.sv
// ---------------------------------------------------------------------------
// wifi_preamble_pkg
// Shared types, frame-layout constants and the 802.11a/g legacy preamble
// sample tables used by the preamble generator and its ROM.
//   state_t      : generator FSM state encoding
//   rom_sel_t    : ROM table select (short or long training symbol)
//   STS_I/STS_Q  : 16-sample short training symbol period, Q1.15
//   LTS_I/LTS_Q  : 64-sample long training symbol, Q1.15
// Table entries are round(value * 2^15) of the 802.11a time-domain tables.
// ---------------------------------------------------------------------------
package wifi_preamble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STS    = 3'd1,
    ST_LTS_GI = 3'd2,
    ST_LTS1   = 3'd3,
    ST_LTS2   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  typedef enum logic {
    ROM_STS = 1'b0,
    ROM_LTS = 1'b1
  } rom_sel_t;

  localparam logic [8:0] STS_LEN   = 9'd160;
  localparam logic [8:0] GI_LEN    = 9'd32;
  localparam logic [8:0] LTS_LEN   = 9'd64;
  localparam logic [8:0] FRAME_LEN = 9'd320;

  // Index of the last beat of each frame section.
  localparam logic [8:0] STS_END   = STS_LEN - 9'd1;
  localparam logic [8:0] GI_END    = STS_LEN + GI_LEN - 9'd1;
  localparam logic [8:0] LTS1_END  = STS_LEN + GI_LEN + LTS_LEN - 9'd1;
  localparam logic [8:0] FRAME_END = FRAME_LEN - 9'd1;

  localparam logic signed [15:0] STS_I [16] = '{
    16'sd1507, -16'sd4325, -16'sd426,  16'sd4686,
    16'sd3015,  16'sd4686, -16'sd426, -16'sd4325,
    16'sd1507,  16'sd66,   -16'sd2589, -16'sd426,
    16'sd0,    -16'sd426,  -16'sd2589,  16'sd66
  };

  localparam logic signed [15:0] STS_Q [16] = '{
    16'sd1507,  16'sd66,   -16'sd2589, -16'sd426,
    16'sd0,    -16'sd426,  -16'sd2589,  16'sd66,
    16'sd1507, -16'sd4325, -16'sd426,   16'sd4686,
    16'sd3015,  16'sd4686, -16'sd426,  -16'sd4325
  };

  localparam logic signed [15:0] LTS_I [64] = '{
     16'sd5112, -16'sd164,   16'sd1311,  16'sd3178,
     16'sd688,   16'sd1966, -16'sd3768, -16'sd1245,
     16'sd3211,  16'sd1737,  16'sd33,   -16'sd4489,
     16'sd786,   16'sd1933, -16'sd721,   16'sd3899,
     16'sd2032,  16'sd1212, -16'sd1868, -16'sd4293,
     16'sd2687,  16'sd2294, -16'sd1966, -16'sd1835,
    -16'sd1147, -16'sd3998, -16'sd4162,  16'sd2458,
    -16'sd98,   -16'sd3015,  16'sd3015,  16'sd393,
    -16'sd5112,  16'sd393,   16'sd3015, -16'sd3015,
    -16'sd98,    16'sd2458, -16'sd4162, -16'sd3998,
    -16'sd1147, -16'sd1835, -16'sd1966,  16'sd2294,
     16'sd2687, -16'sd4293, -16'sd1868,  16'sd1212,
     16'sd2032,  16'sd3899, -16'sd721,   16'sd1933,
     16'sd786,  -16'sd4489,  16'sd33,    16'sd1737,
     16'sd3211, -16'sd1245, -16'sd3768,  16'sd1966,
     16'sd688,   16'sd3178,  16'sd1311, -16'sd164
  };

  localparam logic signed [15:0] LTS_Q [64] = '{
     16'sd0,    -16'sd3932, -16'sd3637,  16'sd2720,
     16'sd918,  -16'sd2884, -16'sd1802, -16'sd3473,
    -16'sd852,   16'sd131,  -16'sd3768, -16'sd1540,
    -16'sd1933, -16'sd492,   16'sd5276, -16'sd164,
     16'sd2032, -16'sd3211, -16'sd1278, -16'sd2130,
    -16'sd3015, -16'sd459,  -16'sd2654,  16'sd721,
     16'sd4948,  16'sd557,   16'sd688,   16'sd2425,
    -16'sd1769,  16'sd3768,  16'sd3473,  16'sd3211,
     16'sd0,    -16'sd3211, -16'sd3473, -16'sd3768,
     16'sd1769, -16'sd2425, -16'sd688,  -16'sd557,
    -16'sd4948, -16'sd721,   16'sd2654,  16'sd459,
     16'sd3015,  16'sd2130,  16'sd1278,  16'sd3211,
    -16'sd2032,  16'sd164,  -16'sd5276,  16'sd492,
     16'sd1933,  16'sd1540,  16'sd3768, -16'sd131,
     16'sd852,   16'sd3473,  16'sd1802,  16'sd2884,
    -16'sd918,  -16'sd2720,  16'sd3637,  16'sd3932
  };

  // Beats below STS_LEN come from the short-symbol table, the rest from
  // the long-symbol table.
  function automatic rom_sel_t beat_to_sel(input logic [8:0] beat);
    if (beat < STS_LEN) begin
      return ROM_STS;
    end else begin
      return ROM_LTS;
    end
  endfunction

endpackage

// File: rtl/preamble_rom.sv
// ---------------------------------------------------------------------------
// preamble_rom
// Combinational lookup of one preamble sample with amplitude scaling.
//   i_sel   : ROM_STS selects the 16-entry short table (address bits [3:0]),
//             ROM_LTS selects the 64-entry long table (address bits [5:0])
//   i_addr  : sample address
//   o_data  : {I[31:16], Q[15:0]}, each arithmetically shifted right by
//             AMP_SHIFT with the sign preserved (truncating, no rounding)
// ---------------------------------------------------------------------------
module preamble_rom
  import wifi_preamble_pkg::*;
#(
  parameter int unsigned AMP_SHIFT = 0
) (
  input  rom_sel_t    i_sel,
  input  logic [5:0]  i_addr,
  output logic [31:0] o_data
);

  logic signed [15:0] w_i;
  logic signed [15:0] w_q;
  logic signed [15:0] w_i_scaled;
  logic signed [15:0] w_q_scaled;

  // Table select and sample fetch.
  always_comb begin
    w_i = 16'sd0;
    w_q = 16'sd0;
    case (i_sel)
      ROM_STS: begin
        w_i = STS_I[i_addr[3:0]];
        w_q = STS_Q[i_addr[3:0]];
      end
      ROM_LTS: begin
        w_i = LTS_I[i_addr];
        w_q = LTS_Q[i_addr];
      end
      default: begin
        w_i = 16'sd0;
        w_q = 16'sd0;
      end
    endcase
  end

  assign w_i_scaled = w_i >>> AMP_SHIFT;
  assign w_q_scaled = w_q >>> AMP_SHIFT;
  assign o_data     = {w_i_scaled, w_q_scaled};

endmodule

// File: rtl/preamble_generator.sv
// ---------------------------------------------------------------------------
// preamble_generator
// Emits 802.11a/g legacy preambles over AXI-Stream: 160 STS beats, the
// 32-beat LTS guard interval and two 64-beat LTS symbols (320 beats per
// frame), with GAP_SAMPLES zero beats between frames of a burst.
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   start_in              : start request, accepted only in IDLE
//   abort_in              : stop after the current frame (sticky)
//   num_frames_in         : frames per burst, 0 = continuous
//   preamble_axis_*       : registered AXI-Stream master, tdata = {I, Q}
//   busy_out              : high whenever the FSM is not IDLE
//   frame_cnt_out         : frames completed in the current burst
// ---------------------------------------------------------------------------
module preamble_generator
  import wifi_preamble_pkg::*;
#(
  parameter int unsigned GAP_SAMPLES = 400,
  parameter int unsigned AMP_SHIFT   = 0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic [7:0]  num_frames_in,
  output logic        preamble_axis_tvalid,
  output logic [31:0] preamble_axis_tdata,
  output logic        preamble_axis_tlast,
  input  logic        preamble_axis_tready,
  output logic        busy_out,
  output logic [7:0]  frame_cnt_out
);

  localparam logic [15:0] GAP_LAST = (GAP_SAMPLES > 32'd0) ?
                                     16'(GAP_SAMPLES - 32'd1) : 16'd0;
  localparam logic        GAP_EN   = (GAP_SAMPLES > 32'd0);

  state_t      r_state;
  logic [8:0]  r_beat;
  logic [15:0] r_gap_cnt;
  logic [7:0]  r_num_frames;
  logic [7:0]  r_frame_cnt;
  logic        r_abort_pending;
  logic        r_tvalid;
  logic        r_tlast;
  logic [31:0] r_tdata;
  logic        r_busy;

  state_t      w_nxt_state;
  logic [8:0]  w_nxt_beat;
  logic [15:0] w_nxt_gap;
  logic        w_hs;
  logic        w_start_acc;
  logic        w_frame_end;
  logic        w_adv;
  logic        w_abort_eff;
  logic        w_burst_done;
  logic [7:0]  w_frame_cnt_inc;
  rom_sel_t    w_rom_sel;
  logic [5:0]  w_rom_addr;
  logic [31:0] w_rom_data;
  logic [31:0] w_nxt_tdata;
  logic        w_nxt_tlast;

  assign w_hs            = r_tvalid && preamble_axis_tready;
  // An abort arriving on the final handshake of a frame still counts.
  assign w_abort_eff     = r_abort_pending || abort_in;
  assign w_frame_cnt_inc = r_frame_cnt + 8'd1;
  assign w_burst_done    = (r_num_frames != 8'd0) &&
                           (w_frame_cnt_inc == r_num_frames);
  assign w_adv           = w_start_acc || w_hs;

  // Next-state, next-beat and gap-counter computation.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_beat  = r_beat;
    w_nxt_gap   = r_gap_cnt;
    w_start_acc = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_start_acc = 1'b1;
          w_nxt_state = ST_STS;
          w_nxt_beat  = 9'd0;
          w_nxt_gap   = 16'd0;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_STS: begin
        if (w_hs) begin
          w_nxt_beat = r_beat + 9'd1;
          if (r_beat == STS_END) begin
            w_nxt_state = ST_LTS_GI;
          end else begin
            w_nxt_state = ST_STS;
          end
        end else begin
          w_nxt_state = ST_STS;
        end
      end
      ST_LTS_GI: begin
        if (w_hs) begin
          w_nxt_beat = r_beat + 9'd1;
          if (r_beat == GI_END) begin
            w_nxt_state = ST_LTS1;
          end else begin
            w_nxt_state = ST_LTS_GI;
          end
        end else begin
          w_nxt_state = ST_LTS_GI;
        end
      end
      ST_LTS1: begin
        if (w_hs) begin
          w_nxt_beat = r_beat + 9'd1;
          if (r_beat == LTS1_END) begin
            w_nxt_state = ST_LTS2;
          end else begin
            w_nxt_state = ST_LTS1;
          end
        end else begin
          w_nxt_state = ST_LTS1;
        end
      end
      ST_LTS2: begin
        if (w_hs) begin
          if (r_beat == FRAME_END) begin
            w_frame_end = 1'b1;
            w_nxt_beat  = 9'd0;
            w_nxt_gap   = 16'd0;
            if (w_abort_eff || w_burst_done) begin
              w_nxt_state = ST_IDLE;
            end else if (GAP_EN) begin
              w_nxt_state = ST_GAP;
            end else begin
              w_nxt_state = ST_STS;
            end
          end else begin
            w_nxt_beat  = r_beat + 9'd1;
            w_nxt_state = ST_LTS2;
          end
        end else begin
          w_nxt_state = ST_LTS2;
        end
      end
      ST_GAP: begin
        if (w_hs) begin
          if (w_abort_eff) begin
            w_nxt_state = ST_IDLE;
          end else if (r_gap_cnt == GAP_LAST) begin
            w_nxt_state = ST_STS;
            w_nxt_beat  = 9'd0;
            w_nxt_gap   = 16'd0;
          end else begin
            w_nxt_state = ST_GAP;
            w_nxt_gap   = r_gap_cnt + 16'd1;
          end
        end else begin
          w_nxt_state = ST_GAP;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_beat  = 9'd0;
        w_nxt_gap   = 16'd0;
      end
    endcase
  end

  // Beat index modulo 64 addresses every long-table section directly
  // (160->32, 192->0, 256->0) and modulo 16 the short table.
  assign w_rom_sel  = beat_to_sel(w_nxt_beat);
  assign w_rom_addr = w_nxt_beat[5:0];

  preamble_rom #(
    .AMP_SHIFT (AMP_SHIFT)
  ) u_rom (
    .i_sel  (w_rom_sel),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  // Output payload for the beat that will be presented next.
  always_comb begin
    w_nxt_tdata = 32'd0;
    w_nxt_tlast = 1'b0;
    case (w_nxt_state)
      ST_STS, ST_LTS_GI, ST_LTS1: begin
        w_nxt_tdata = w_rom_data;
        w_nxt_tlast = 1'b0;
      end
      ST_LTS2: begin
        w_nxt_tdata = w_rom_data;
        w_nxt_tlast = (w_nxt_beat == FRAME_END);
      end
      default: begin
        w_nxt_tdata = 32'd0;
        w_nxt_tlast = 1'b0;
      end
    endcase
  end

  // FSM, beat index and output register; only move on start or handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= ST_IDLE;
      r_beat    <= 9'd0;
      r_gap_cnt <= 16'd0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= 32'd0;
      r_busy    <= 1'b0;
    end else if (w_adv) begin
      r_state   <= w_nxt_state;
      r_beat    <= w_nxt_beat;
      r_gap_cnt <= w_nxt_gap;
      r_tvalid  <= (w_nxt_state != ST_IDLE);
      r_tlast   <= w_nxt_tlast;
      r_tdata   <= w_nxt_tdata;
      r_busy    <= (w_nxt_state != ST_IDLE);
    end else begin
      r_state   <= r_state;
      r_beat    <= r_beat;
      r_gap_cnt <= r_gap_cnt;
      r_tvalid  <= r_tvalid;
      r_tlast   <= r_tlast;
      r_tdata   <= r_tdata;
      r_busy    <= r_busy;
    end
  end

  // Burst bookkeeping: frame target and completed-frame counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_num_frames <= 8'd0;
      r_frame_cnt  <= 8'd0;
    end else if (w_start_acc) begin
      r_num_frames <= num_frames_in;
      r_frame_cnt  <= 8'd0;
    end else if (w_frame_end) begin
      r_num_frames <= r_num_frames;
      r_frame_cnt  <= w_frame_cnt_inc;
    end else begin
      r_num_frames <= r_num_frames;
      r_frame_cnt  <= r_frame_cnt;
    end
  end

  // Sticky abort request; ignored while idle, cleared when a start is taken.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_abort_pending <= 1'b0;
    end else if (w_start_acc) begin
      r_abort_pending <= 1'b0;
    end else if ((r_state != ST_IDLE) && abort_in) begin
      r_abort_pending <= 1'b1;
    end else begin
      r_abort_pending <= r_abort_pending;
    end
  end

  assign preamble_axis_tvalid = r_tvalid;
  assign preamble_axis_tdata  = r_tdata;
  assign preamble_axis_tlast  = r_tlast;
  assign busy_out             = r_busy;
  assign frame_cnt_out        = r_frame_cnt;

endmodule
